mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multiply/divide unit controller for the 5-stage pipeline. Accepts one MDU operation per start from the E stage and latches its operands. It holds the pipeline through a fixed multi-cycle latency, then commits the 64-bit result into HI/LO. It raises a stall request to the hazard logic whenever the instruction in D needs the MDU while an operation is in flight.

## Interface
Parameters:
- MUL_CYCLES, default 5: busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, default 10: busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  E-stage instruction is an MDU op; sampled at the edge.
- op  in  3  MDU opcode, encodings from mdu_pkg: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- a  in  32  rs operand, forwarded value from E.
- b  in  32  rt operand, forwarded value from E.
- md_d  in  1  D-stage instruction is any MDU user (mult/div/mthi/mtlo/mfhi/mflo).
- busy  out  1  a MULT/DIV operation is in progress.
- stall_req  out  1  combinational: md_d & (busy | (start & op is MULT/MULTU/DIV/DIVU)).
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- FSM states: IDLE, MUL, DIV.
- IDLE + start + MULT/MULTU:
  - latch a, b and the signedness flag;
  - load the counter with MUL_CYCLES;
  - go to MUL.
- IDLE + start + DIV/DIVU: same latching; load the counter with DIV_CYCLES; go to DIV.
- IDLE + start + MTHI: hi <= a at this edge; no busy. MTLO writes lo <= a the same way.
- MUL/DIV:
  - decrement the counter each cycle;
  - when the counter is 1, commit the result into hi/lo at that edge and return to IDLE.
- Multiply:
  - signed is a 64-bit two's-complement product; unsigned zero-extends both operands;
  - hi = product[63:32], lo = product[31:0].
- Divide:
  - lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend;
  - DIVU is the unsigned equivalent.
  - Divisor 0: hi/lo are left unchanged, but the full DIV_CYCLES latency still elapses.
  - 0x80000000 / 0xFFFFFFFF (signed): lo = 0x80000000, hi = 0.
- start while busy:
  - illegal, since stall_req prevents it;
  - it is ignored, and the in-flight op completes unchanged;
  - a bench assertion flags it.
- Opcode values outside the list: start is ignored.

## Timing
- Reset values: state IDLE, counter 0, busy 0, hi 0, lo 0, latched operands 0. stall_req is then md_d & start & (mult/div op).
- Reset asserted mid-operation aborts immediately: busy falls asynchronously and hi/lo return to 0.
- start sampled at edge T:
  - busy is 1 during cycles T+1 .. T+N (N = MUL_CYCLES or DIV_CYCLES);
  - hi/lo change at the edge ending cycle T+N;
  - the new values are visible together with busy = 0 in cycle T+N+1.
- MTHI/MTLO sampled at edge T: the new value is visible from cycle T+1, zero latency.
- stall_req has zero latency relative to start; it covers the start cycle itself.
- Back-to-back ops:
  - a new start is accepted in the first cycle in which busy = 0, i.e. T+N+1;
  - the MDU is never idle between ops for longer than the stall logic requires.

## Structure
- Package mdu_pkg: op encodings (3-bit localparams), FSM state encoding, and the counter width (4 bits).
- One combinational sub-module, mdu_compute, is natural:
  - inputs: latched operands, signed flag, mul/div select;
  - outputs: res_hi, res_lo, div_by_zero.
- mdu_ctrl holds the FSM, the counter, the operand latches and HI/LO.

## Test plan
- Reset and MULT:
  - apply reset, then MULT a=0xFFFFFFFE (-2), b=3 at edge T;
  - busy 1 for cycles T+1..T+5;
  - at T+6: hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- MULTU and DIV:
  - MULTU a=0xFFFFFFFF, b=2 gives hi=0x00000001, lo=0xFFFFFFFE;
  - DIV a=-7, b=2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF, with busy lasting exactly 10 cycles.
- Divide by zero:
  - preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIV a=5, b=0;
  - busy lasts 10 cycles; hi=0x11 and lo=0x22 are retained.
- Stall:
  - DIVU issued with md_d=1 in the same cycle: stall_req=1 in the start cycle and through all 10 busy cycles;
  - stall_req=0 in cycle T+11.
  - With md_d=0 in the same scenario, stall_req stays 0 throughout.
- Reset mid-operation:
  - deassert rst_n in cycle T+3 of a MULT;
  - busy=0 and hi=lo=0 immediately;
  - after release, a DIVU 100/7 completes with lo=14, hi=2.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit controller:
// opcode encodings, FSM state encoding and counter width.
package mdu_pkg;

  localparam int CNT_W = 4;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_t;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage / hazard-logic side of the MDU: operation request, stall request
// and the architectural HI/LO registers.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_d;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, md_d,
                  input  busy, stall_req, hi, lo);
  modport slave  (input  start, op, a, b, md_d,
                  output busy, stall_req, hi, lo);
endinterface

// File: rtl/mdu_compute.sv
// Combinational multiply/divide datapath on the latched operands.
// Division truncates toward zero; the remainder follows the dividend's sign.
module mdu_compute (
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        sgn,
  input  logic        mul_sel,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic        neg_a, neg_b;
  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] mag_a, mag_b, q_mag, r_mag, quot, rem;

  always_comb begin
    neg_a       = sgn & op_a[31];
    neg_b       = sgn & op_b[31];
    ext_a       = {{32{neg_a}}, op_a};
    ext_b       = {{32{neg_b}}, op_b};
    prod        = ext_a * ext_b;

    // Magnitude division; 0x80000000 / -1 wraps back to 0x80000000 on negation.
    mag_a       = neg_a ? (32'd0 - op_a) : op_a;
    mag_b       = neg_b ? (32'd0 - op_b) : op_b;
    div_by_zero = (op_b == 32'd0);
    q_mag       = div_by_zero ? 32'd0 : (mag_a / mag_b);
    r_mag       = div_by_zero ? 32'd0 : (mag_a % mag_b);
    quot        = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    rem         = neg_a ? (32'd0 - r_mag) : r_mag;

    res_hi      = mul_sel ? prod[63:32] : rem;
    res_lo      = mul_sel ? prod[31:0]  : quot;
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: latches one mult/div op, holds busy for a fixed latency,
// then commits the result into HI/LO. MTHI/MTLO write with zero latency.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   ST_IDLE | no op in flight; accepts start
//   ST_MUL  | multiply in flight, counter counts down to commit
//   ST_DIV  | divide in flight, counter counts down to commit
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic  clk,
  input  logic  rst_n,
  mdu_if.slave  bus
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

  mdu_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      a_q, b_q, hi_q, lo_q;
  logic             sgn_q, busy_q;
  logic [31:0]      res_hi, res_lo;
  logic             div_by_zero;

  mdu_compute u_compute (
    .op_a        (a_q),
    .op_b        (b_q),
    .sgn         (sgn_q),
    .mul_sel     (state_q == ST_MUL),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (is_muldiv(bus.op)) begin
              a_q    <= bus.a;
              b_q    <= bus.b;
              sgn_q  <= is_signed_op(bus.op);
              busy_q <= 1'b1;
              if ((bus.op == OP_MULT) || (bus.op == OP_MULTU)) begin
                cnt_q   <= MUL_LOAD;
                state_q <= ST_MUL;
              end else begin
                cnt_q   <= DIV_LOAD;
                state_q <= ST_DIV;
              end
            end else if (bus.op == OP_MTHI) begin
              hi_q <= bus.a;
            end else if (bus.op == OP_MTLO) begin
              lo_q <= bus.a;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            // A zero divisor still burns the full latency but leaves HI/LO alone.
            if (!((state_q == ST_DIV) && div_by_zero)) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.stall_req = bus.md_d & (busy_q | (bus.start & is_muldiv(bus.op)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: expected HI/LO pushed at issue, popped when
// busy falls; busy length and stall_req checked every cycle.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [63:0] sb[$];
  logic [63:0] model_hl = 64'd0;

  mdu_if bus();

  mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && bus.start) begin
      assert (bus.busy === 1'b0)
      else begin
        miscompares++;
        $error("FAIL start_while_busy: observed busy=%0b expected 0", bus.busy);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
    longint          sa = longint'($signed(a));
    longint          sb_ = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          q, r;
    longint unsigned uq, ur;
    case (op)
      OP_MULT:  return 64'(sa * sb_);
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 32'd0) return cur;
        q = sa / sb_;
        r = sa % sb_;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return cur;
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return cur;
    endcase
  endfunction

  // Called just after a falling edge; returns right after the sampling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic md);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.md_d  = md;
    #1;
    chk("stall_start", {31'd0, bus.stall_req}, {31'd0, md & is_muldiv(op)});
    if (is_muldiv(op)) begin
      model_hl = ref_res(op, a, b, model_hl);
      sb.push_back(model_hl);
    end else if (op == OP_MTHI) begin
      model_hl[63:32] = a;
    end else if (op == OP_MTLO) begin
      model_hl[31:0] = a;
    end
    @(posedge clk);
  endtask

  task automatic wait_done(input string tag, input int n_exp, input logic md);
    int n = 0;
    bit done = 1'b0;
    logic [63:0] exp;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.busy) begin
        n++;
        chk({tag, "_stall_busy"}, {31'd0, bus.stall_req}, {31'd0, md});
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_timeout: observed busy still 1 after 40 cycles, expected 0", tag);
    end
    chk({tag, "_busy_cycles"}, n, n_exp);
    chk({tag, "_stall_after"}, {31'd0, bus.stall_req}, 32'd0);
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_scoreboard: observed empty queue, expected one entry", tag);
    end else begin
      exp = sb.pop_front();
      chk({tag, "_hi"}, bus.hi, exp[63:32]);
      chk({tag, "_lo"}, bus.lo, exp[31:0]);
    end
  endtask

  task automatic single_cycle(input logic [2:0] op, input logic [31:0] a, input string tag);
    issue(op, a, 32'd1, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_hi"}, bus.hi, model_hl[63:32]);
    chk({tag, "_lo"}, bus.lo, model_hl[31:0]);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.a     = '0;
    bus.b     = '0;
    bus.md_d  = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    bus.start = 1'b1;
    bus.md_d  = 1'b1;
    bus.op    = OP_MULT;
    #1;
    chk("rst_stall_mult", {31'd0, bus.stall_req}, 32'd1);
    bus.op = OP_MTHI;
    #1;
    chk("rst_stall_mthi", {31'd0, bus.stall_req}, 32'd0);
    bus.start = 1'b0;
    bus.md_d  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_done("mult", 5, 1'b0);
    chk("plan_mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("plan_mult_lo", bus.lo, 32'hFFFF_FFFA);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_done("multu", 5, 1'b0);
    chk("plan_multu_hi", bus.hi, 32'h0000_0001);
    chk("plan_multu_lo", bus.lo, 32'hFFFF_FFFE);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done("div", 10, 1'b0);
    chk("plan_div_hi", bus.hi, 32'hFFFF_FFFF);
    chk("plan_div_lo", bus.lo, 32'hFFFF_FFFD);

    single_cycle(OP_MTHI, 32'h11, "mthi");
    single_cycle(OP_MTLO, 32'h22, "mtlo");
    issue(OP_DIV, 32'd5, 32'd0, 1'b0);
    wait_done("div0", 10, 1'b0);
    chk("plan_div0_hi", bus.hi, 32'h11);
    chk("plan_div0_lo", bus.lo, 32'h22);

    issue(OP_DIVU, 32'd1000, 32'd3, 1'b1);
    wait_done("divu_stall", 10, 1'b1);
    chk("plan_divu_hi", bus.hi, 32'd1);
    chk("plan_divu_lo", bus.lo, 32'd333);
    bus.md_d = 1'b0;

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done("div_ovf", 10, 1'b0);
    chk("plan_ovf_hi", bus.hi, 32'h0);
    chk("plan_ovf_lo", bus.lo, 32'h8000_0000);

    single_cycle(3'd7, 32'hDEAD_BEEF, "bad_op");

    for (int k = 0; k < 4; k++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (k == 1) ? 32'($urandom_range(1, 9)) : $urandom;
      issue(rop, ra, rb, 1'b0);
      wait_done("rand", (rop == OP_MULT || rop == OP_MULTU) ? 5 : 10, 1'b0);
    end

    single_cycle(OP_MTLO, 32'h5A, "mtlo2");
    issue(OP_MULT, 32'd3, 32'd5, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("midop_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    sb.delete();
    model_hl = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
    wait_done("divu_post_rst", 10, 1'b0);
    chk("plan_post_rst_hi", bus.hi, 32'd2);
    chk("plan_post_rst_lo", bus.lo, 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
